// File: rtl/i2c_target_regfile.sv
// I2C target with a 7-bit address match and an auto-incrementing pointer into a
// byte-wide register file; SDA is driven open-drain through sda_oe.
module i2c_target_regfile #(
  parameter logic [6:0]  TARGET_ADDR = 7'h27,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned PTR_W       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scl_in,
  input  logic                    sda_in,
  output logic                    sda_oe,
  output logic [NUM_REGS*8-1:0]   regs_flat,
  output logic                    wr_strobe,
  output logic [PTR_W-1:0]        wr_index,
  output logic                    busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_e;

  localparam logic [8:0]       NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REGS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   s_scl, s_sda;
  logic                   scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0]             rx_byte_s, rd_byte_s;
  logic [PTR_W-1:0]       next_ptr_s;

  state_e                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic [7:0]             tx_q, tx_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   rw_q, rw_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0]       wr_index_q, wr_index_d;
  logic [NUM_REGS*8-1:0]  regs_q, regs_d;

  // Pin synchronisers plus one extra flop for edge detection, preset to idle-high bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= s_scl;
      sda_prev_q <= s_sda;
    end
  end

  assign s_scl      = scl_sync_q[SYNC_STAGES-1];
  assign s_sda      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_s = s_scl & ~scl_prev_q;
  assign scl_fall_s = ~s_scl & scl_prev_q;
  assign start_s    = s_scl & scl_prev_q & sda_prev_q & ~s_sda;
  assign stop_s     = s_scl & scl_prev_q & ~sda_prev_q & s_sda;
  assign rx_byte_s  = {shift_q, s_sda};
  assign rd_byte_s  = regs_q[{ptr_q, 3'b000} +: 8];
  assign next_ptr_s = (ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : ptr_q + PTR_ONE;

  // Protocol state machine; ACK states use sda_oe_q to tell the 8th fall from the 9th
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    regs_d      = regs_q;
    if (stop_s) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_s) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise_s) begin
            shift_d = rx_byte_s[6:0];
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ADDR) begin
                if (rx_byte_s[7:1] == TARGET_ADDR) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte_s[0];
                end else begin
                  state_d = WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end else if (state_q == PTR) begin
                if ({1'b0, rx_byte_s} < NUM_REGS_W) begin
                  ptr_d   = rx_byte_s[PTR_W-1:0];
                  state_d = PTR_ACK;
                end else begin
                  state_d = WAIT_STOP;
                end
              end else begin
                regs_d[{ptr_q, 3'b000} +: 8] = rx_byte_s;
                wr_strobe_d = 1'b1;
                wr_index_d  = ptr_q;
                ptr_d       = next_ptr_s;
                state_d     = WDATA_ACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall_s) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (state_q == ADDR_ACK && rw_q) begin
              state_d   = RDATA;
              tx_d      = {rd_byte_s[6:0], 1'b0};
              sda_oe_d  = ~rd_byte_s[7];
              bit_cnt_d = 4'd0;
            end else begin
              state_d   = (state_q == ADDR_ACK) ? PTR : WDATA;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        RDATA: begin
          if (scl_rise_s) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              ptr_d     = next_ptr_s;
              bit_cnt_d = 4'd0;
              state_d   = RACK;
            end else begin
              sda_oe_d = ~tx_q[7];
              tx_d     = {tx_q[6:0], 1'b0};
            end
          end else begin
            tx_d = tx_q;
          end
        end
        RACK: begin
          // bit_cnt_q==1 records a master ACK seen on the 9th rise
          if (scl_rise_s) begin
            if (!s_sda) begin
              bit_cnt_d = 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WAIT_STOP;
            end
          end else if (scl_fall_s && bit_cnt_q == 4'd1) begin
            state_d   = RDATA;
            tx_d      = {rd_byte_s[6:0], 1'b0};
            sda_oe_d  = ~rd_byte_s[7];
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        IDLE, WAIT_STOP: begin
          state_d = state_q;
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; async clear releases the bus immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 7'd0;
      tx_q        <= 8'd0;
      ptr_q       <= {PTR_W{1'b0}};
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= {PTR_W{1'b0}};
      regs_q      <= {NUM_REGS{RESET_VAL}};
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      regs_q      <= regs_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign regs_flat = regs_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
`timescale 1ns/1ps
// Bit-banged I2C controller driving the target, with a byte-level model of the
// register file, pointer and expected ACK/NACK behaviour.
module tb_i2c_target_regfile;
  localparam int Q = 40;
  localparam logic [6:0] TADDR = 7'h27;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_scl, m_sda;
  logic        sda_oe, wr_strobe, busy;
  logic [31:0] regs_flat;
  logic [1:0]  wr_index;
  wire         sda_line = m_sda & ~sda_oe;

  int          checks, failures;
  logic [7:0]  m_regs [4];
  int          m_ptr, m_mode;
  bit          m_busy, quiet;
  int          exp_idx[$];
  logic [7:0]  exp_dat[$];
  int          strobe_log[$];
  logic        oe_prev, scl_prev;
  logic [7:0]  d;

  i2c_target_regfile #(.TARGET_ADDR(7'h27), .NUM_REGS(4), .PTR_W(2), .SYNC_STAGES(2),
                       .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(m_scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_flat();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_mode = 0; m_busy = 1'b0;
    exp_idx.delete(); exp_dat.delete();
  endtask

  // mode: 0 ignore, 1 address, 2 pointer, 3 write data, 4 read data
  task automatic model_wbyte(input logic [7:0] b, output bit ack);
    ack = 1'b0;
    case (m_mode)
      1: if (b[7:1] == TADDR) begin ack = 1'b1; m_busy = 1'b1; m_mode = b[0] ? 4 : 2; end
         else begin m_busy = 1'b0; m_mode = 0; end
      2: if (int'(b) < 4) begin ack = 1'b1; m_ptr = int'(b); m_mode = 3; end
         else m_mode = 0;
      3: begin
        ack = 1'b1; m_regs[m_ptr] = b;
        exp_idx.push_back(m_ptr); exp_dat.push_back(b);
        m_ptr = (m_ptr + 1) % 4;
      end
      default: ack = 1'b0;
    endcase
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    m_sda = b; #(Q); m_scl = 1'b1; #(Q); s = sda_line; #(Q); m_scl = 1'b0; #(Q);
  endtask

  task automatic start_c();
    m_sda = 1'b1; #(Q); m_scl = 1'b1; #(2*Q); m_sda = 1'b0; #(2*Q); m_scl = 1'b0; #(Q);
    m_mode = 1;
  endtask

  task automatic stop_c();
    m_sda = 1'b0; #(Q); m_scl = 1'b1; #(2*Q); m_sda = 1'b1; #(2*Q);
    m_mode = 0; m_busy = 1'b0;
    chk("busy_after_stop", busy, 1'b0);
    chk("pending_strobes", exp_idx.size(), 0);
    chk("regs_vs_model", regs_flat, model_flat());
  endtask

  task automatic wr(input logic [7:0] b);
    bit ea; logic s;
    model_wbyte(b, ea);
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    chk($sformatf("ack_%02h", b), {31'd0, ~s}, {31'd0, ea});
    chk($sformatf("busy_%02h", b), busy, m_busy);
  endtask

  task automatic rd(input bit mack, output logic [7:0] dv);
    logic s; logic [7:0] e;
    e = m_regs[m_ptr]; m_ptr = (m_ptr + 1) % 4;
    for (int i = 7; i >= 0; i--) begin bit_xfer(1'b1, s); dv[i] = s; end
    bit_xfer(~mack, s);
    if (!mack) m_mode = 0;
    chk("rdata_model", dv, e);
  endtask

  initial begin
    checks = 0; failures = 0; quiet = 1'b0;
    m_scl = 1'b1; m_sda = 1'b1; rst_n = 1'b1; oe_prev = 1'b0; scl_prev = 1'b1;
    m_reset();
    fork
      begin
        int ei; logic [7:0] ed;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            chk("reset_outputs", {29'd0, sda_oe, busy, wr_strobe}, 32'd0);
          end else begin
            if (wr_strobe) begin
              strobe_log.push_back(int'(wr_index));
              if (exp_idx.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_strobe: wr_index=%0d, expected no write", wr_index);
              end else begin
                ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
                chk("wr_index", wr_index, ei);
                chk("wr_data", regs_flat[{wr_index, 3'b000} +: 8], ed);
              end
            end
            if (quiet) chk("quiet_oe", sda_oe, 1'b0);
            if (scl_prev && m_scl) chk("oe_stable_scl_high", sda_oe, oe_prev);
          end
          oe_prev = sda_oe; scl_prev = m_scl;
        end
      end
    join_none

    #1 rst_n = 1'b0;
    #51 rst_n = 1'b1;
    #(Q);
    chk("rst_regs", regs_flat, 32'h0000_0000);
    chk("rst_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobe", wr_strobe, 1'b0);
    chk("rst_index", wr_index, 2'd0);

    // Multi-byte write
    strobe_log.delete();
    start_c(); wr(8'h4E); wr(8'h01); wr(8'hA5); wr(8'h5A); stop_c();
    chk("t1_reg1", regs_flat[15:8], 8'hA5);
    chk("t1_reg2", regs_flat[23:16], 8'h5A);
    chk("t1_nstrobe", strobe_log.size(), 2);
    chk("t1_idx0", strobe_log[0], 1);
    chk("t1_idx1", strobe_log[1], 2);

    // Preload, then read with repeated START and pointer wrap
    start_c(); wr(8'h4E); wr(8'h00); wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44); stop_c();
    start_c(); wr(8'h4E); wr(8'h03); start_c(); wr(8'h4F);
    rd(1'b1, d); chk("t2_rd0", d, 8'h44);
    rd(1'b1, d); chk("t2_rd1", d, 8'h11);
    rd(1'b0, d); chk("t2_rd2", d, 8'h22);
    chk("t2_oe_after_nack", sda_oe, 1'b0);
    stop_c();

    // Address mismatch
    strobe_log.delete();
    quiet = 1'b1;
    start_c(); wr(8'h50); wr(8'h12); wr(8'h34); stop_c();
    quiet = 1'b0;
    chk("t3_nstrobe", strobe_log.size(), 0);

    // Out-of-range pointer
    start_c(); wr(8'h4E); wr(8'h07); wr(8'h99); stop_c();
    chk("t4_regs", regs_flat, 32'h4433_2211);

    // Partial data byte cut by STOP
    strobe_log.delete();
    start_c(); wr(8'h4E); wr(8'h00);
    begin
      logic s;
      bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b1, s);
    end
    stop_c();
    chk("t5_reg0", regs_flat[7:0], 8'h11);
    chk("t5_nstrobe", strobe_log.size(), 0);

    // Reset during a read while the target drives SDA low
    start_c(); wr(8'h4F);
    chk("t6_oe_driving", sda_oe, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("t6_oe_async", sda_oe, 1'b0);
    chk("t6_regs_reset", regs_flat, 32'h0000_0000);
    m_scl = 1'b1; m_sda = 1'b1; m_reset();
    #38 rst_n = 1'b1;
    #(2*Q);
    start_c(); wr(8'h4F); rd(1'b0, d); chk("t6_ptr_reset_rd", d, 8'h00); stop_c();
    start_c(); wr(8'h4E); wr(8'h02); wr(8'hC3); stop_c();
    start_c(); wr(8'h4E); wr(8'h02); start_c(); wr(8'h4F);
    rd(1'b0, d); chk("t6_readback", d, 8'hC3); stop_c();

    #(2*Q);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- Synthesizable I2C target (slave) that replaces the fixed "ACK every 9th SCL fall" bench model with a protocol-correct responder.
- Decodes START, STOP and repeated START; matches a parametrised 7-bit address; ACKs correctly.
- Supports multi-byte writes and reads through an auto-incrementing pointer into a NUM_REGS x 8 register file.
- Sits on the open-drain SDA/SCL bus beside the I2C controller: as the bench target for the controller, and as an on-chip config port.

Parameters:
- TARGET_ADDR, 7'h27, 7-bit bus address the block responds to.
- NUM_REGS, 4, register count, 1..256.
- PTR_W, 2, pointer width; ceil(log2(NUM_REGS)), minimum 1.
- SYNC_STAGES, 2, synchroniser depth on scl_in/sda_in, 2..4.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk, input, 1, system clock; at least 16x SCL frequency.
- rst_n, input, 1, asynchronous active-low reset.
- scl_in, input, 1, SCL pin level (asynchronous).
- sda_in, input, 1, SDA pin level (asynchronous).
- sda_oe, output, 1, 1 = pull SDA low; top level drives sda = sda_oe ? 1'b0 : 1'bz.
- regs_flat, output, NUM_REGS*8, register file; reg i is at bits [8i+7:8i].
- wr_strobe, output, 1, one-clk pulse per register written.
- wr_index, output, PTR_W, index of the register written; valid with wr_strobe.
- busy, output, 1, high from address match until STOP, or until the next START if that ends the transfer.

Behaviour:
- Reset (async, rst_n=0):
  - sda_oe=0, wr_strobe=0, wr_index=0, busy=0, every register=RESET_VAL, pointer=0.
  - State IDLE; synchronisers preset to 1.
- Synchronisation:
  - scl_in and sda_in each pass through SYNC_STAGES flops; all logic uses the synced values s_scl/s_sda.
  - Edges are detected with one extra flop.
  - START = s_sda falls while s_scl=1. STOP = s_sda rises while s_scl=1. Both are detected from any state.
- Bit timing:
  - Input bits are sampled on s_scl rising edge, MSB first.
  - sda_oe changes only on an s_scl falling edge, within SYNC_STAGES+2 clk of the falling edge of scl_in.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
- IDLE: START -> ADDR, bit count=0.
- ADDR: shift in 8 bits.
  - If [7:1]==TARGET_ADDR: ACK (sda_oe=1 from the 8th SCL fall to the 9th SCL fall) and set busy.
  - R/W=0 -> PTR. R/W=1 -> RDATA, with the first bit driven at the 9th SCL fall.
  - On mismatch: sda_oe stays 0 -> WAIT_STOP.
- PTR: the byte loads the pointer.
  - If the value is < NUM_REGS: ACK -> WDATA.
  - Otherwise NACK, pointer unchanged -> WAIT_STOP.
- WDATA: after 8 bits, write reg[ptr], pulse wr_strobe with wr_index=ptr (one clk, at the 8th SCL rise+1), ACK.
  - Pointer increments and wraps NUM_REGS-1 -> 0.
  - Further bytes repeat WDATA.
- RDATA:
  - Shift register loads reg[ptr] at the 9th SCL fall of the previous byte.
  - sda_oe = ~bit for each bit; release (sda_oe=0) at the 8th SCL fall.
  - Pointer increments (with wrap) at byte end. -> RACK.
- RACK: sample master ACK at the 9th SCL rise. ACK (0) -> RDATA. NACK (1) -> WAIT_STOP with sda_oe=0.
- WAIT_STOP: ignores bits; only START/STOP act.
- STOP (any state): -> IDLE, sda_oe=0 immediately, busy=0. The pointer is retained.
- Repeated START (any state): -> ADDR, sda_oe=0 immediately, pointer retained, partial byte discarded with no write.
  - busy stays 1 only if the new address matches.
- Simultaneous events:
  - A START/STOP detected in the same clk as an SCL edge takes priority.
  - A partial write byte interrupted by START/STOP never writes the register.
- Reset mid-transfer: immediate return to the reset state. The bus is released the same cycle via async clear of sda_oe.

Test Plan:
- Write 0x4E, 0x01, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg1=0xA5, reg2=0x5A; two wr_strobe pulses, wr_index 1 then 2; busy low after STOP.
- Preload reg0..3=11,22,33,44. Write 0x4E, 0x03; repeated START; 0x4F; read 3 bytes (ACK, ACK, NACK); STOP -> reads return 44, 11, 22 (wrap); sda_oe=0 after NACK.
- Address 0x50 (mismatch) followed by 2 data bytes -> sda_oe never asserted, busy=0, no wr_strobe.
- Pointer 0x07 with NUM_REGS=4 -> NACK on the pointer byte; a following data byte is ignored; registers unchanged.
- START plus 0x4E, 0x00, then 4 data bits, then STOP -> reg0 unchanged, no wr_strobe, state IDLE.
- rst_n asserted low during a read while sda_oe=1 -> sda_oe=0 within the same cycle (async); registers=RESET_VAL; the next full transaction completes normally.
